// File: rtl/gate_seq_pkg.sv
// Shared encodings for the gate test sequencer: gate modes, FSM states and the
// reserved-mode check.
package gate_seq_pkg;

   typedef enum logic [2:0] {
      MODE_INV  = 3'd0,
      MODE_AND  = 3'd1,
      MODE_OR   = 3'd2,
      MODE_NAND = 3'd3,
      MODE_NOR  = 3'd4,
      MODE_XOR  = 3'd5
   } gate_mode_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_APPLY  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_CHECK  = 3'd3,
      ST_DONE   = 3'd4
   } seq_state_e;

   function automatic logic mode_is_reserved(input logic [2:0] mode);
      return mode > 3'd5;
   endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model: expected gate output for a (mode, vector) pair.
module gate_ref_model
   import gate_seq_pkg::*;
#(
   parameter int WIDTH = 2
) (
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] vec,
   output logic             expected
);

   always_comb begin
      expected = 1'b0;
      case (mode)
         MODE_INV:  expected = ~vec[0];
         MODE_AND:  expected = &vec;
         MODE_OR:   expected = |vec;
         MODE_NAND: expected = ~&vec;
         MODE_NOR:  expected = ~|vec;
         MODE_XOR:  expected = ^vec;
         default:   expected = 1'b0;
      endcase
   end

endmodule

// File: rtl/gate_test_sequencer.sv
// Exhaustive gate tester: walks every input vector, waits SETTLE cycles, compares
// against gate_ref_model. Define GATE_SEQ_STOP_ON_FAIL_EN to end a run on the first mismatch.
module gate_test_sequencer
   import gate_seq_pkg::*;
#(
   parameter int WIDTH  = 2,
   parameter int SETTLE = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       mode,
   output logic [WIDTH-1:0] gate_in,
   input  logic             gate_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [WIDTH:0]   err_count,
   output logic [WIDTH-1:0] fail_vec
);

   localparam int EW = WIDTH + 1;
   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam logic [WIDTH-1:0] INV_LAST = WIDTH'(1);

   seq_state_e       state_q, state_d;
   logic [2:0]       mode_q, mode_d;
   logic [WIDTH-1:0] gate_in_q, gate_in_d;
   logic [WIDTH-1:0] fail_vec_q, fail_vec_d;
   logic [EW-1:0]    err_q, err_d;
   logic [3:0]       settle_q, settle_d;
   logic             pass_q, pass_d;
   logic             rsvd_q, rsvd_d;
   logic             expected, mismatch, last_vec;

   gate_ref_model #(.WIDTH(WIDTH)) u_ref (
      .mode     (mode_q),
      .vec      (gate_in_q),
      .expected (expected)
   );

   assign mismatch = (gate_out != expected);
   // INV only exercises bit 0, so its sweep stops at vector 1.
   assign last_vec = (gate_in_q == ((mode_q == MODE_INV) ? INV_LAST : ALL_ONES));

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      gate_in_d  = gate_in_q;
      fail_vec_d = fail_vec_q;
      err_d      = err_q;
      settle_d   = settle_q;
      pass_d     = pass_q;
      rsvd_d     = rsvd_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mode_d     = mode;
               err_d      = '0;
               fail_vec_d = '0;
               pass_d     = 1'b0;
               rsvd_d     = mode_is_reserved(mode);
               if (mode_is_reserved(mode)) begin
                  state_d = ST_DONE;
               end else begin
                  gate_in_d = '0;
                  state_d   = ST_APPLY;
               end
            end
         end
         ST_APPLY: begin
            settle_d = 4'(SETTLE);
            state_d  = ST_SETTLE;
         end
         ST_SETTLE: begin
            settle_d = settle_q - 4'd1;
            if (settle_q == 4'd1) state_d = ST_CHECK;
         end
         ST_CHECK: begin
            if (mismatch) begin
               err_d = err_q + EW'(1);
               if (err_q == '0) fail_vec_d = gate_in_q;
            end
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
            if (mismatch || last_vec) begin
               state_d = ST_DONE;
            end else begin
               gate_in_d = gate_in_q + WIDTH'(1);
               state_d   = ST_APPLY;
            end
`else
            if (last_vec) begin
               state_d = ST_DONE;
            end else begin
               gate_in_d = gate_in_q + WIDTH'(1);
               state_d   = ST_APPLY;
            end
`endif
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // pass is resolved on entry to DONE so it is already valid alongside the done pulse.
      if (state_d == ST_DONE && state_q != ST_DONE) pass_d = !rsvd_d && (err_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         mode_q     <= '0;
         gate_in_q  <= '0;
         fail_vec_q <= '0;
         err_q      <= '0;
         settle_q   <= '0;
         pass_q     <= 1'b0;
         rsvd_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         gate_in_q  <= gate_in_d;
         fail_vec_q <= fail_vec_d;
         err_q      <= err_d;
         settle_q   <= settle_d;
         pass_q     <= pass_d;
         rsvd_q     <= rsvd_d;
      end
   end

   assign gate_in   = gate_in_q;
   assign busy      = (state_q == ST_APPLY) || (state_q == ST_SETTLE) || (state_q == ST_CHECK);
   assign done      = (state_q == ST_DONE);
   assign pass      = pass_q;
   assign err_count = err_q;
   assign fail_vec  = fail_vec_q;

endmodule
